// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Requester identity, memory request bundle and default memory size.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CORE = 2'd1,
        SRC_DBG  = 2'd2
    } req_src_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam int unsigned MEM_BYTES_DEFAULT = 4096;

    function automatic logic in_range(
        input logic [31:0] addr,
        input int unsigned bytes
    );
        return addr < bytes;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin arbiter.
// Bit 0 = core, bit 1 = dbg; prio_q names the side that wins a tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
        // after a grant, the loser gets the next tie
        if (gnt_o != 2'b00) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the load/store unit and the debug port.
// One access per cycle; responses return one cycle after acceptance.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_valid,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_ready,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,
    input  logic        dbg_valid,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ready,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic        mem_we,
    output logic [31:0] mem_read_addr,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    logic [1:0] req;
    logic [1:0] gnt;
    mem_req_t   sel;
    req_src_t   src_d, src_q;
    logic       err_d, err_q;
    logic       rd_d, rd_q;

    assign req = {dbg_valid & ~reset, core_valid & ~reset};

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign core_ready = gnt[0];
    assign dbg_ready  = gnt[1];

    always_comb begin
        sel   = '0;
        src_d = SRC_NONE;
        unique case (1'b1)
            gnt[0]: begin
                sel   = '{we: core_we, addr: core_addr, wdata: core_wdata};
                src_d = SRC_CORE;
            end
            gnt[1]: begin
                sel   = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
                src_d = SRC_DBG;
            end
            default: ;
        endcase
        // an out-of-range access still uses the slot but never reaches memory
        err_d          = (src_d != SRC_NONE) && !in_range(sel.addr, MEM_BYTES);
        rd_d           = (src_d != SRC_NONE) && !sel.we && !err_d;
        mem_we         = (src_d != SRC_NONE) && sel.we && !err_d;
        mem_write_addr = mem_we ? sel.addr : '0;
        mem_write_data = mem_we ? sel.wdata : '0;
        mem_read_addr  = rd_d ? sel.addr : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q <= SRC_NONE;
            err_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            src_q <= src_d;
            err_q <= err_d;
            rd_q  <= rd_d;
        end
    end

    // a response still in flight when reset arrives is suppressed
    assign core_rvalid = !reset && (src_q == SRC_CORE);
    assign dbg_rvalid  = !reset && (src_q == SRC_DBG);
    assign core_err    = core_rvalid && err_q;
    assign dbg_err     = dbg_rvalid && err_q;
    assign core_rdata  = (core_rvalid && rd_q) ? mem_read_data : '0;
    assign dbg_rdata   = (dbg_rvalid && rd_q) ? mem_read_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a word-array memory
// and a queue-based reference of grants and responses.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_valid, core_we, dbg_valid, dbg_we;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic        core_ready, core_rvalid, core_err;
    logic        dbg_ready, dbg_rvalid, dbg_err;
    logic [31:0] core_rdata, dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_read_addr, mem_write_addr, mem_write_data;
    logic [31:0] mem_read_data;

    dmem_arbiter #(.MEM_BYTES(4096)) dut (
        .clk            (clk),
        .reset          (reset),
        .core_valid     (core_valid),
        .core_we        (core_we),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_ready     (core_ready),
        .core_rvalid    (core_rvalid),
        .core_rdata     (core_rdata),
        .core_err       (core_err),
        .dbg_valid      (dbg_valid),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_ready      (dbg_ready),
        .dbg_rvalid     (dbg_rvalid),
        .dbg_rdata      (dbg_rdata),
        .dbg_err        (dbg_err),
        .mem_we         (mem_we),
        .mem_read_addr  (mem_read_addr),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    typedef enum int {S_NONE, S_CORE, S_DBG} side_e;
    typedef struct {
        side_e       side;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mem [0:1023];
    logic [15:0] stdout_q;
    logic        preload;
    logic [31:0] ref_mem [int];
    bit          prio_core = 1'b1;
    bit          got_core, got_dbg;
    logic        last_core_ready, last_dbg_ready;
    logic [5:0]  seq;

    function automatic logic [31:0] init_word(input int w);
        if (w == 4) return 32'hDEADBEEF;
        return (32'(w) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int w;
        w = int'(a / 4);
        if (ref_mem.exists(w)) return ref_mem[w];
        return init_word(w);
    endfunction

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 32'h0000_1000;
        if (r == 1) return 32'h0000_0FFC;
        if (r == 2) return $urandom() | 32'h0000_1000;
        return 32'($urandom_range(0, 4095));
    endfunction

    // Data memory: registered read, write lands before a later read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            stdout_q <= 16'h0;
        end else if (mem_we) begin
            mem[mem_write_addr[11:2]] <= mem_write_data;
            if (mem_write_addr == 32'h0) stdout_q <= mem_write_data[15:0];
        end
        mem_read_data <= mem[mem_read_addr[11:2]];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the expectation due this cycle.
    always @(negedge clk) begin
        rsp_t e;
        bit   ec, ed;
        ec = 1'b0;
        ed = 1'b0;
        e  = '{side: S_NONE, err: 1'b0, rdata: 32'h0, cyc: 0};
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            ec = (e.side == S_CORE);
            ed = (e.side == S_DBG);
        end
        chk("core_rvalid", 32'(core_rvalid), 32'(ec));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(ed));
        if (ec) begin
            chk("core_rdata", core_rdata, e.rdata);
            chk("core_err", 32'(core_err), 32'(e.err));
        end
        if (ed) begin
            chk("dbg_rdata", dbg_rdata, e.rdata);
            chk("dbg_err", 32'(dbg_err), 32'(e.err));
        end
    end

    // Grant model: round-robin by pointer, predicts memory port and response.
    task automatic check_grant();
        side_e       g;
        logic        we, bad, ewe;
        logic [31:0] a, wd, rd;
        g = S_NONE; we = 1'b0; a = '0; wd = '0; rd = '0;
        if (reset) prio_core = 1'b1;
        else if (core_valid && dbg_valid) g = prio_core ? S_CORE : S_DBG;
        else if (core_valid) g = S_CORE;
        else if (dbg_valid) g = S_DBG;
        if (g != S_NONE) prio_core = (g == S_DBG);
        if (g == S_CORE) begin
            we = core_we; a = core_addr; wd = core_wdata;
        end else if (g == S_DBG) begin
            we = dbg_we; a = dbg_addr; wd = dbg_wdata;
        end
        bad = (g != S_NONE) && (a >= 32'd4096);
        ewe = (g != S_NONE) && we && !bad;
        chk("core_ready", 32'(core_ready), 32'(g == S_CORE));
        chk("dbg_ready", 32'(dbg_ready), 32'(g == S_DBG));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        last_core_ready = core_ready;
        last_dbg_ready  = dbg_ready;
        if (ewe) begin
            chk("mem_write_addr", mem_write_addr, a);
            chk("mem_write_data", mem_write_data, wd);
        end else if (g != S_NONE && !we && !bad) begin
            chk("mem_read_addr", mem_read_addr, a);
        end else if (g == S_NONE) begin
            chk("idle_read_addr", mem_read_addr, 32'h0);
            chk("idle_write_addr", mem_write_addr, 32'h0);
            chk("idle_write_data", mem_write_data, 32'h0);
        end
        if (g != S_NONE) begin
            if (!we && !bad) rd = ref_read(a);
            if (ewe) ref_mem[int'(a / 4)] = wd;
            exp_q.push_back('{side: g, err: bad, rdata: rd, cyc: cyc + 1});
        end
        got_core = (g == S_CORE);
        got_dbg  = (g == S_DBG);
        if (reset) begin
            chk("rst_core_rdata", core_rdata, 32'h0);
            chk("rst_dbg_rdata", dbg_rdata, 32'h0);
            chk("rst_core_err", 32'(core_err), 32'h0);
            chk("rst_dbg_err", 32'(dbg_err), 32'h0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_grant();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input bit v, input bit we,
                            input logic [31:0] a, input logic [31:0] d);
        core_valid = v; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_dbg(input bit v, input bit we,
                           input logic [31:0] a, input logic [31:0] d);
        dbg_valid = v; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        preload = 1'b1;
        set_core(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        @(posedge clk);
        #1;
        preload = 1'b0;

        // request held through reset is not granted until reset drops
        set_core(1, 0, 32'h10, 32'h0);
        step();
        reset = 1'b0;
        step();
        chk("core_first_read_ready", 32'(last_core_ready), 32'h1);
        core_valid = 1'b0;
        step();

        // contention after reset alternates starting with core
        do_reset();
        set_core(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if (!core_valid) set_core(1, 0, 32'($urandom_range(0, 4095)), 0);
            if (!dbg_valid) set_dbg(1, 1, 32'($urandom_range(0, 4095)), $urandom());
            step();
            seq[i] = last_dbg_ready;
            if (got_core) core_valid = 1'b0;
            if (got_dbg) dbg_valid = 1'b0;
        end
        chk("alternation", 32'(seq), 32'(6'b101010));
        set_core(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        step();

        // write then immediate read of the same word
        set_dbg(1, 1, 32'h20, 32'h12345678);
        step();
        dbg_valid = 1'b0;
        set_core(1, 0, 32'h20, 32'h0);
        step();
        core_valid = 1'b0;
        step();

        // out-of-range write at the first illegal address
        set_core(1, 1, 32'h1000, 32'hCAFEF00D);
        step();
        core_valid = 1'b0;
        step();

        // reset kills a pending response and the pointer
        set_dbg(1, 0, 32'h8, 32'h0);
        step();
        dbg_valid = 1'b0;
        set_core(1, 0, 32'h40, 32'h0);
        step();
        core_valid = 1'b0;
        do_reset();
        step();
        set_core(1, 0, 32'h44, 32'h0);
        set_dbg(1, 0, 32'h48, 32'h0);
        step();
        chk("post_reset_core_first", 32'(last_core_ready), 32'h1);
        core_valid = 1'b0;
        step();
        dbg_valid = 1'b0;
        step();

        // stdout write reaches memory untouched
        set_dbg(1, 1, 32'h0, 32'h41);
        step();
        dbg_valid = 1'b0;
        step();
        chk("stdout", 32'(stdout_q), 32'h0041);

        // random traffic with hold-until-ready requesters
        for (int n = 0; n < 600; n++) begin
            if (!core_valid || got_core) begin
                if ($urandom_range(0, 9) < 7)
                    set_core(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom());
                else
                    core_valid = 1'b0;
            end
            if (!dbg_valid || got_dbg) begin
                if ($urandom_range(0, 9) < 7)
                    set_dbg(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom());
                else
                    dbg_valid = 1'b0;
            end
            if ($urandom_range(0, 99) == 0) do_reset();
            else step();
        end

        set_core(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        repeat (3) step();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
